// File: rtl/xcorr_ctrl_if.sv
// Handshake/result bundle between the cross-correlation controller and its environment.
// Combinational wiring only; the controller's outputs are all registered.
// Backpressure: the source is stalled through src_ready, and the correlator side is never stalled.
interface xcorr_ctrl_if #(
    parameter int INTEGER_SIZE = 16,
    parameter int FRACT_SIZE   = 16,
    parameter int NFFT         = 128
);
    localparam int DATA_WIDTH = INTEGER_SIZE + FRACT_SIZE;
    localparam int IDXW       = $clog2(NFFT);

    logic                         req;
    logic                         busy;
    logic                         src_valid;
    logic                         src_ready;
    logic                         start_FFT;
    logic                         data_valid_IFFT;
    logic                         end_IFFT;
    logic signed [DATA_WIDTH-1:0] corr_r;
    logic signed [DATA_WIDTH-1:0] corr_i;
    logic        [IDXW-1:0]       peak_idx;
    logic        [DATA_WIDTH:0]   peak_mag;
    logic                         done;
    logic                         err_underrun;
    logic                         err_short;
    logic                         err_timeout;

    modport master (
        output req, src_valid, data_valid_IFFT, end_IFFT, corr_r, corr_i,
        input  busy, src_ready, start_FFT, peak_idx, peak_mag, done,
               err_underrun, err_short, err_timeout
    );

    modport slave (
        input  req, src_valid, data_valid_IFFT, end_IFFT, corr_r, corr_i,
        output busy, src_ready, start_FFT, peak_idx, peak_mag, done,
               err_underrun, err_short, err_timeout
    );
endinterface

// File: rtl/xcorr_ctrl.sv
// Frame sequencer and peak detector for the FFT/IFFT correlator; the WAIT/SCAN watchdog is built under XCORR_CTRL_TIMEOUT_EN.
// Latency: req -> start_FFT in 2 cycles; done is 1 cycle after the last scanned sample; all outputs are registered.
// Backpressure: loading starts only once src_valid is high, and a src_valid drop mid-load aborts the frame; IFFT input is never stalled.
module xcorr_ctrl #(
    parameter int INTEGER_SIZE   = 16,
    parameter int FRACT_SIZE     = 16,
    parameter int NFFT           = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    xcorr_ctrl_if.slave  bus
);
    localparam int DATA_WIDTH = INTEGER_SIZE + FRACT_SIZE;
    localparam int IDXW       = $clog2(NFFT);
    localparam logic [IDXW-1:0] LAST = IDXW'(NFFT - 1);

    generate
        if (NFFT < 2 || (NFFT & (NFFT - 1)) != 0) begin : g_bad_nfft
            $error("xcorr_ctrl: NFFT must be a power of two >= 2");
        end
        if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
            $error("xcorr_ctrl: TIMEOUT_CYCLES must be >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_LOAD, S_WAIT, S_SCAN, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [IDXW-1:0]       cnt_q, cnt_d;
    logic [IDXW-1:0]       peak_idx_q, peak_idx_d;
    logic [DATA_WIDTH:0]   peak_mag_q, peak_mag_d;
    logic                  err_underrun_q, err_underrun_d;
    logic                  err_short_q, err_short_d;
    logic                  err_timeout_q, err_timeout_d;
    logic                  busy_q, busy_d;
    logic                  src_ready_q, src_ready_d;
    logic                  start_q, start_d;
    logic                  done_q, done_d;

    // Sign-extend by one bit so |most-negative| is representable without saturation.
    logic [DATA_WIDTH:0] ext_r, ext_i, abs_r, abs_i, mag;
    assign ext_r = {bus.corr_r[DATA_WIDTH-1], bus.corr_r};
    assign ext_i = {bus.corr_i[DATA_WIDTH-1], bus.corr_i};
    assign abs_r = ext_r[DATA_WIDTH] ? -ext_r : ext_r;
    assign abs_i = ext_i[DATA_WIDTH] ? -ext_i : ext_i;
    assign mag   = abs_r + abs_i;

    logic tmo_hit;
`ifdef XCORR_CTRL_TIMEOUT_EN
    localparam int TMOW = $clog2(TIMEOUT_CYCLES);
    logic [TMOW-1:0] tmo_q, tmo_d;

    assign tmo_hit = (state_q == S_WAIT || state_q == S_SCAN) &&
                     (tmo_q == TMOW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = tmo_q;
        if (state_q == S_LOAD) begin
            tmo_d = '0;
        end else if (state_q == S_WAIT || state_q == S_SCAN) begin
            tmo_d = tmo_q + TMOW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        peak_idx_d     = peak_idx_q;
        peak_mag_d     = peak_mag_q;
        err_underrun_d = err_underrun_q;
        err_short_d    = err_short_q;
        err_timeout_d  = err_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    state_d        = S_ARM;
                    peak_idx_d     = '0;
                    peak_mag_d     = '0;
                    err_underrun_d = 1'b0;
                    err_short_d    = 1'b0;
                    err_timeout_d  = 1'b0;
                end
            end
            S_ARM: begin
                if (bus.src_valid) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (!bus.src_valid) begin
                    err_underrun_d = 1'b1;
                    state_d        = S_DONE;
                end else if (cnt_q == LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IDXW'(1);
                end
            end
            S_WAIT, S_SCAN: begin
                if (bus.data_valid_IFFT) begin
                    // Strict compare keeps the earliest bin on ties; bin 0 always seeds the peak.
                    if (cnt_q == '0 || mag > peak_mag_q) begin
                        peak_mag_d = mag;
                        peak_idx_d = cnt_q;
                    end
                    cnt_d = cnt_q + IDXW'(1);
                    if (cnt_q == LAST) begin
                        state_d = S_DONE;
                    end else if (bus.end_IFFT) begin
                        err_short_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_SCAN;
                    end
                end else if (state_q == S_SCAN && bus.end_IFFT) begin
                    err_short_d = 1'b1;
                    state_d     = S_DONE;
                end
                if (tmo_hit && state_d != S_DONE) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control outputs are decoded from the next state so they are registered yet cycle-aligned.
    always_comb begin
        busy_d      = (state_d != S_IDLE);
        src_ready_d = (state_d == S_LOAD);
        start_d     = (state_d == S_LOAD) && (state_q == S_ARM);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            peak_idx_q     <= '0;
            peak_mag_q     <= '0;
            err_underrun_q <= 1'b0;
            err_short_q    <= 1'b0;
            err_timeout_q  <= 1'b0;
            busy_q         <= 1'b0;
            src_ready_q    <= 1'b0;
            start_q        <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            peak_idx_q     <= peak_idx_d;
            peak_mag_q     <= peak_mag_d;
            err_underrun_q <= err_underrun_d;
            err_short_q    <= err_short_d;
            err_timeout_q  <= err_timeout_d;
            busy_q         <= busy_d;
            src_ready_q    <= src_ready_d;
            start_q        <= start_d;
            done_q         <= done_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.src_ready    = src_ready_q;
    assign bus.start_FFT    = start_q;
    assign bus.done         = done_q;
    assign bus.peak_idx     = peak_idx_q;
    assign bus.peak_mag     = peak_mag_q;
    assign bus.err_underrun = err_underrun_q;
    assign bus.err_short    = err_short_q;
    assign bus.err_timeout  = err_timeout_q;
endmodule

// File: tb/tb_xcorr_ctrl.sv
// Directed bench for xcorr_ctrl: stimulus pushes expected frame results, a done-triggered monitor pops and compares.
module tb_xcorr_ctrl;
    localparam int NFFT = 128;
    localparam int DW   = 32;
`ifdef XCORR_CTRL_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    xcorr_ctrl_if #(.INTEGER_SIZE(16), .FRACT_SIZE(16), .NFFT(NFFT)) bus ();

    xcorr_ctrl #(
        .INTEGER_SIZE(16), .FRACT_SIZE(16), .NFFT(NFFT), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [6:0]  idx;
        logic [32:0] mag;
        logic        und;
        logic        sht;
        logic        tmo;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    logic signed [DW-1:0] vr [NFFT];
    logic signed [DW-1:0] vi [NFFT];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1, required no completion");
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_peak_idx",     64'(bus.peak_idx),     64'(mon_e.idx));
                chk("sb_peak_mag",     64'(bus.peak_mag),     64'(mon_e.mag));
                chk("sb_err_underrun", 64'(bus.err_underrun), 64'(mon_e.und));
                chk("sb_err_short",    64'(bus.err_short),    64'(mon_e.sht));
                chk("sb_err_timeout",  64'(bus.err_timeout),  64'(mon_e.tmo));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_vec();
        for (int i = 0; i < NFFT; i++) begin
            vr[i] = '0;
            vi[i] = '0;
        end
    endtask

    // Called right after tick(); issues req and runs the load phase, returning timing stats.
    task automatic load_frame(input int drop_at, output int n_ready, output int n_start,
                              output int start_ofs, output int last_ofs);
        n_ready = 0; n_start = 0; start_ofs = -1; last_ofs = -1;
        bus.src_valid = 1'b1;
        bus.req       = 1'b1;
        for (int c = 1; c < NFFT + 40; c++) begin
            tick();
            bus.req = 1'b0;
            if (bus.start_FFT === 1'b1) begin
                n_start++;
                start_ofs = c;
            end
            if (bus.src_ready === 1'b1) begin
                if (n_ready == drop_at) bus.src_valid = 1'b0;
                n_ready++;
                last_ofs = c;
            end else if (n_ready > 0) begin
                break;
            end
        end
        bus.src_valid = 1'b0;
    endtask

    // Feeds n_samp valid IFFT samples with periodic gaps; end_IFFT rides on the last one.
    task automatic scan_frame(input int n_samp, input bit req_mid, input string tag);
        int k = 0;
        int cyc = 0;
        repeat (3) tick();
        while (k < n_samp) begin
            bus.req = 1'b0;
            if ((cyc % 5) == 2) begin
                bus.data_valid_IFFT = 1'b0;
                bus.end_IFFT        = 1'b0;
            end else begin
                bus.data_valid_IFFT = 1'b1;
                bus.corr_r          = vr[k];
                bus.corr_i          = vi[k];
                bus.end_IFFT        = (k == n_samp - 1);
                bus.req             = req_mid && (k == 30);
                k++;
            end
            tick();
            cyc++;
        end
        bus.req = 1'b0; bus.data_valid_IFFT = 1'b0; bus.end_IFFT = 1'b0;
        bus.corr_r = '0; bus.corr_i = '0;
        chk({tag, "_done_latency"}, 64'(bus.done), 64'd1);
        tick();
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        chk({tag, "_idle_after"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic run_frame(input int n_samp, input bit req_mid, input string tag);
        int nr, ns, so, lo;
        load_frame(-1, nr, ns, so, lo);
        chk({tag, "_ready_cycles"}, 64'(nr), 64'(NFFT));
        chk({tag, "_start_count"},  64'(ns), 64'd1);
        chk({tag, "_start_ofs"},    64'(so), 64'd2);
        chk({tag, "_ready_last"},   64'(lo), 64'(NFFT + 1));
        scan_frame(n_samp, req_mid, tag);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int nr, ns, so, lo, cnt;
        bus.req = 1'b0; bus.src_valid = 1'b0; bus.data_valid_IFFT = 1'b0;
        bus.end_IFFT = 1'b0; bus.corr_r = '0; bus.corr_i = '0;
        #3 rst = 1'b0;
        #4;
        chk("reset_busy",      64'(bus.busy),         64'd0);
        chk("reset_src_ready", 64'(bus.src_ready),    64'd0);
        chk("reset_start",     64'(bus.start_FFT),    64'd0);
        chk("reset_done",      64'(bus.done),         64'd0);
        chk("reset_peak_idx",  64'(bus.peak_idx),     64'd0);
        chk("reset_peak_mag",  64'(bus.peak_mag),     64'd0);
        chk("reset_errs",      64'({bus.err_underrun, bus.err_short, bus.err_timeout}), 64'd0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Impulse at bin 5.
        clear_vec();
        vr[5] = 32'h0001_0000;
        exp_q.push_back('{idx: 7'd5, mag: 33'h0_0001_0000, und: 1'b0, sht: 1'b0, tmo: 1'b0});
        run_frame(NFFT, 1'b0, "nominal");

        // Tie at 100/120, most-negative real part at 127 -> signed lag -1.
        clear_vec();
        vr[100] = 32'h0000_8000;
        vr[120] = 32'h0000_4000;
        vi[120] = 32'hFFFF_C000;
        vr[127] = 32'h8000_0000;
        exp_q.push_back('{idx: 7'd127, mag: 33'h0_8000_0000, und: 1'b0, sht: 1'b0, tmo: 1'b0});
        run_frame(NFFT, 1'b0, "neg_lag");

        vr[127] = '0;
        exp_q.push_back('{idx: 7'd100, mag: 33'h0_0000_8000, und: 1'b0, sht: 1'b0, tmo: 1'b0});
        run_frame(NFFT, 1'b0, "tie");

        // Underrun at load count 60.
        exp_q.push_back('{idx: 7'd0, mag: 33'h0, und: 1'b1, sht: 1'b0, tmo: 1'b0});
        load_frame(60, nr, ns, so, lo);
        chk("underrun_ready_cycles", 64'(nr), 64'd61);
        chk("underrun_start_count",  64'(ns), 64'd1);
        chk("underrun_done_next",    64'(bus.done), 64'd1);
        tick();
        chk("underrun_done_pulse",   64'(bus.done), 64'd0);
        chk("underrun_idle_after",   64'(bus.busy), 64'd0);

        // Short frame ending on the 64th valid sample, with a req pulse during SCAN.
        clear_vec();
        vr[10] = 32'hFFFF_EDCC;
        vi[10] = 32'h0000_0100;
        vr[40] = 32'h0000_1334;
        vr[70] = 32'h0010_0000;
        exp_q.push_back('{idx: 7'd10, mag: 33'h0_0000_1334, und: 1'b0, sht: 1'b1, tmo: 1'b0});
        run_frame(64, 1'b1, "short");
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.busy !== 1'b0 || bus.start_FFT !== 1'b0) cnt++;
        end
        chk("req_while_busy_ignored", 64'(cnt), 64'd0);

`ifdef XCORR_CTRL_TIMEOUT_EN
        exp_q.push_back('{idx: 7'd0, mag: 33'h0, und: 1'b0, sht: 1'b0, tmo: 1'b1});
        load_frame(-1, nr, ns, so, lo);
        cnt = 0;
        while (bus.done !== 1'b1 && cnt < 4 * TMO) begin
            tick();
            cnt++;
        end
        chk("timeout_done_seen", 64'(bus.done), 64'd1);
        tick();
`endif

        // Asynchronous reset in the middle of LOAD.
        bus.src_valid = 1'b1;
        bus.req       = 1'b1;
        tick();
        bus.req = 1'b0;
        repeat (12) tick();
        chk("rst_pre_src_ready", 64'(bus.src_ready), 64'd1);
        #3 rst = 1'b0;
        #1;
        chk("rst_async_busy",      64'(bus.busy),      64'd0);
        chk("rst_async_src_ready", 64'(bus.src_ready), 64'd0);
        chk("rst_async_done",      64'(bus.done),      64'd0);
        chk("rst_async_result",    64'({bus.peak_idx, bus.peak_mag, bus.start_FFT,
                                         bus.err_underrun, bus.err_short, bus.err_timeout}), 64'd0);
        tick(); tick();
        rst = 1'b1;
        bus.src_valid = 1'b0;
        repeat (3) tick();
        chk("rst_release_idle",  64'(bus.busy),      64'd0);
        chk("rst_release_ready", 64'(bus.src_ready), 64'd0);

        clear_vec();
        vi[3] = 32'hFFFF_FFFF;
        exp_q.push_back('{idx: 7'd3, mag: 33'h0_0000_0001, und: 1'b0, sht: 1'b0, tmo: 1'b0});
        run_frame(NFFT, 1'b0, "recover");

        repeat (5) tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/xcorr_ctrl.md
# xcorr_ctrl

Frame sequencer and peak detector for the FFT/IFFT cross-correlation datapath. It arms on a software/upstream request, gates exactly NFFT samples from the sample source into the correlator, and issues the `start_FFT` pulse. It then scans the serial IFFT output for the maximum-magnitude bin and reports that bin's index as the lag estimate. It sits between the capture buffers and the synchronisation/coefficient-estimation logic.

## Interface
- `INTEGER_SIZE`, 16, integer bits of correlator samples
- `FRACT_SIZE`, 16, fractional bits; DATA_WIDTH = INTEGER_SIZE+FRACT_SIZE
- `NFFT`, 128, frame length; power of two; IDXW = log2(NFFT)
- `TIMEOUT_CYCLES`, 1024, watchdog limit for WAIT+SCAN
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req`  in  1  start one frame; sampled only in IDLE
- `busy`  out  1  high in every state except IDLE
- `src_valid`  in  1  sample source has data
- `src_ready`  out  1  sample accepted this cycle, to both correlator inputs
- `start_FFT`  out  1  one-cycle pulse to the correlator, coincident with the first accepted sample
- `data_valid_IFFT`  in  1  correlator output sample valid
- `end_IFFT`  in  1  correlator frame-end strobe
- `corr_r`, `corr_i`  in  DATA_WIDTH each  signed correlator output
- `peak_idx`  out  IDXW  bin of maximum magnitude; as two's complement it is the signed lag
- `peak_mag`  out  DATA_WIDTH+1  unsigned |r|+|i| at the peak
- `done`  out  1  one-cycle completion pulse
- `err_underrun`, `err_short`, `err_timeout`  out  1 each  sticky error flags; cleared on the next accepted `req`

## Operation
- States: IDLE, ARM, LOAD, WAIT, SCAN, DONE.
- **IDLE.** `req`=1 moves to ARM and clears the error flags, `peak_idx` and `peak_mag`.
- **ARM.** Wait for `src_valid`=1, then go to LOAD.
  - The correlator cannot stall, so loading starts only once the source is ready.
- **LOAD.**
  - `src_ready`=1 for exactly NFFT consecutive cycles. A load counter counts 0..NFFT-1.
  - `start_FFT`=1 in the first LOAD cycle only.
  - `src_valid`=0 in any LOAD cycle sets `err_underrun` and goes to DONE. The frame is aborted and outputs keep their cleared values.
  - After count NFFT-1, go to WAIT.
- **WAIT.** The first `data_valid_IFFT`=1 enters SCAN; that sample is scanned in the same cycle.
- **SCAN.**
  - Each valid sample has index k = the number of prior valid samples.
  - Magnitude: mag = |corr_r| + |corr_i|, computed in DATA_WIDTH+1 bits. The abs of the most-negative value is 2^(DATA_WIDTH-1); no saturation is needed.
  - Update `peak_mag`/`peak_idx` only when mag > `peak_mag` (strict greater-than). Ties keep the earliest bin.
  - Sample k=0 always loads.
  - After the sample with k=NFFT-1, go to DONE.
  - `end_IFFT`=1 while fewer than NFFT samples have been seen (including the current one) sets `err_short` and goes to DONE with the partial peak.
  - `end_IFFT` on the final sample is normal completion.
- **DONE.** `done`=1 for one cycle, then IDLE. Results hold until the next `req`.
- `req` while `busy`=1 is ignored; it is not queued.

## Timing
- Reset (`rst`=0, async):
  - State goes to IDLE.
  - All outputs are 0: `busy`, `src_ready`, `start_FFT`, `done`, `peak_idx`, `peak_mag` and the error flags.
  - Reset mid-frame abandons the frame immediately; no `done` is produced.
- `req` at cycle t gives ARM at t+1.
- With `src_valid` already high, `start_FFT` and the first `src_ready` occur at t+2.
- `src_ready` is high for cycles t+2..t+NFFT+1.
- `start_FFT`, `src_ready`, `busy` and `done` are registered outputs, decoded from state.
- Datapath latency (`start_FFT` to first `data_valid_IFFT`) is set by the correlator. This block makes no assumption about it beyond the watchdog.
- `peak_idx`/`peak_mag` are final in the same cycle `done` is high.
- `done` is asserted one cycle after the last scanned sample.
- The scan tolerates gaps in `data_valid_IFFT`; k advances only on valid samples.

## Configuration
- Macro `XCORR_CTRL_TIMEOUT_EN`.
- **Defined:**
  - A counter runs in WAIT and SCAN and is reset on entry to WAIT.
  - When it reaches TIMEOUT_CYCLES-1, `err_timeout` is set and the state goes to DONE.
  - In SCAN, a valid sample on that same cycle is still scanned first.
- **Undefined:**
  - No counter is built; WAIT/SCAN wait indefinitely.
  - `err_timeout` is tied to 0.

## Test plan
- **Nominal frame.** Drive an impulse at bin 5: mag 0x0001_0000 at k=5, 0 elsewhere. Expect `done` one cycle after the 128th valid sample, `peak_idx`=5, `peak_mag`=0x0_0001_0000, and no error flags.
- **Negative lag and tie.** Drive equal mags of 0x8000 at k=100 and k=120, plus corr_r=-0x8000_0000 at k=127. Expect `peak_idx`=127 (signed -1) and `peak_mag`=0x0_8000_0000. A second run without k=127 expects `peak_idx`=100.
- **Underrun.** Drop `src_valid` at load count 60. Expect `err_underrun`=1, one `done` pulse, `src_ready` low from the next cycle, and `start_FFT` pulsed exactly once.
- **Short frame and req-while-busy.** Assert `end_IFFT` on the 64th valid sample. Expect `err_short`=1 and `done`. A `req` pulse issued during SCAN produces no second frame.
- **Timeout and reset.**
  - With `XCORR_CTRL_TIMEOUT_EN` and TIMEOUT_CYCLES=16, and `data_valid_IFFT` never asserted: expect `err_timeout`=1 at WAIT entry+15, then `done`.
  - Separately, drive `rst`=0 mid-LOAD. Expect all outputs at 0 asynchronously and IDLE after release.
